// File: rtl/pixel_source_switch_if.sv
// Pixel-source switch bus: raw select, raster position, the four pixel
// sources, and the registered RGB / status returned to the display side.
//
// master : the surrounding system (sources, vga_display counters, switches)
// slave  : pixel_source_switch
interface pixel_source_switch_if;
    logic [2:0]  output_select;
    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic [11:0] rom_rgb;
    logic [11:0] strip_rgb;
    logic [11:0] uart_rgb;
    logic [11:0] gif_rgb;
    logic [3:0]  o_r;
    logic [3:0]  o_g;
    logic [3:0]  o_b;
    logic [2:0]  active_sel;
    logic        switching;

    modport master (
        output output_select, h_cnt, v_cnt,
        output rom_rgb, strip_rgb, uart_rgb, gif_rgb,
        input  o_r, o_g, o_b, active_sel, switching
    );

    modport slave (
        input  output_select, h_cnt, v_cnt,
        input  rom_rgb, strip_rgb, uart_rgb, gif_rgb,
        output o_r, o_g, o_b, active_sel, switching
    );
endinterface

// File: rtl/pixel_source_switch.sv
// pixel_source_switch
// Registered, glitch-free pixel-source selector feeding vga_display. The raw
// slide-switch code is synchronised and debounced; a new source is committed
// only on the first pixel of a frame (h_cnt==0 && v_cnt==0).
//
// Build option: define SWITCH_BLANK_EN to insert BLANK_FRAMES full black
// frames between the old and new source. Without it the source changes
// directly at the frame boundary.
//
// Ports:
//   clk    : divided pixel clock (same clock as vga_display)
//   rst_n  : asynchronous active-low reset
//   pix    : pixel_source_switch_if.slave
//            in : output_select[2:0], h_cnt/v_cnt[10:0],
//                 rom_rgb/strip_rgb/uart_rgb/gif_rgb[11:0]
//            out: o_r/o_g/o_b[3:0] (1-clk registered), active_sel[2:0],
//                 switching
//
// Parameters:
//   DEBOUNCE_CYCLES : clocks the synchronised select must stay constant (>=1)
//   BLANK_FRAMES    : black frames per switch when blanking is built (1..15)
//
// State        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | committed source shown, nothing pending
// S_WAIT_FRAME | debounced code differs from active_sel, waiting for (0,0)
// S_BLANK      | (SWITCH_BLANK_EN only) black frames before committing
module pixel_source_switch #(
    parameter int unsigned DEBOUNCE_CYCLES = 65535,
    parameter int unsigned BLANK_FRAMES    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pixel_source_switch_if.slave  pix
);

    if (DEBOUNCE_CYCLES < 1 || BLANK_FRAMES < 1 || BLANK_FRAMES > 15) begin : g_bad_params
        $error("pixel_source_switch: DEBOUNCE_CYCLES must be >= 1 and BLANK_FRAMES in 1..15");
    end

    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

`ifdef SWITCH_BLANK_EN
    localparam logic [3:0] LAST_FRAME = 4'(BLANK_FRAMES - 1);
    typedef enum logic [1:0] {S_IDLE, S_WAIT_FRAME, S_BLANK} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_WAIT_FRAME} state_t;
`endif

    logic [2:0]       sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       stable_q;

    state_t           state_q, state_d;
    logic [2:0]       active_q, active_d;
    logic             blank_out;
    logic             frame_start;
    logic [11:0]      mapped_rgb;
    logic [11:0]      rgb_q;

`ifdef SWITCH_BLANK_EN
    logic [2:0]       pending_q, pending_d;
    logic [3:0]       frame_cnt_q, frame_cnt_d;
`endif

    assign frame_start = (pix.h_cnt == 11'd0) && (pix.v_cnt == 11'd0);

    // Synchroniser, change detect and saturating debounce counter. stable_q
    // is loaded on the edge where the count arrives at CNT_MAX and simply
    // reloads the same value while the count sits saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 3'b000;
            sync2_q  <= 3'b000;
            prev_q   <= 3'b000;
            cnt_q    <= '0;
            stable_q <= 3'b000;
        end else begin
            sync1_q <= pix.output_select;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (sync2_q != prev_q) begin
                cnt_q <= '0;
            end else begin
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                if (cnt_q >= CNT_MAX - CNT_W'(1)) begin
                    stable_q <= sync2_q;
                end
            end
        end
    end

    // stable_q here is the pre-update value, so a debounce completion on a
    // frame_start cycle is serviced at the following frame.
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        blank_out = 1'b0;
`ifdef SWITCH_BLANK_EN
        pending_d   = pending_q;
        frame_cnt_d = frame_cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (stable_q != active_q) begin
                    state_d = S_WAIT_FRAME;
`ifdef SWITCH_BLANK_EN
                    pending_d = stable_q;
`endif
                end
            end
            S_WAIT_FRAME: begin
`ifdef SWITCH_BLANK_EN
                pending_d = stable_q;
`endif
                if (stable_q == active_q) begin
                    state_d = S_IDLE;
                end else if (frame_start) begin
`ifdef SWITCH_BLANK_EN
                    state_d     = S_BLANK;
                    frame_cnt_d = 4'd0;
                    blank_out   = 1'b1;
`else
                    active_d = stable_q;
                    state_d  = S_IDLE;
`endif
                end
            end
`ifdef SWITCH_BLANK_EN
            S_BLANK: begin
                blank_out = 1'b1;
                if (frame_start) begin
                    if (frame_cnt_q == LAST_FRAME) begin
                        // The commit pixel already shows the new source.
                        active_d  = pending_q;
                        state_d   = S_IDLE;
                        blank_out = 1'b0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 4'd1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Mapping uses the code being committed this cycle so the boundary
    // pixel itself comes from the new source.
    always_comb begin
        mapped_rgb = 12'hFFF;
        case (active_d)
            3'b010:  mapped_rgb = pix.rom_rgb;
            3'b100:  mapped_rgb = pix.strip_rgb;
            3'b110:  mapped_rgb = pix.uart_rgb;
            3'b001:  mapped_rgb = pix.gif_rgb;
            default: mapped_rgb = 12'hFFF;
        endcase
        if (blank_out) begin
            mapped_rgb = 12'h000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            active_q <= 3'b000;
            rgb_q    <= 12'h000;
`ifdef SWITCH_BLANK_EN
            pending_q   <= 3'b000;
            frame_cnt_q <= 4'd0;
`endif
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            rgb_q    <= mapped_rgb;
`ifdef SWITCH_BLANK_EN
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    assign pix.o_r        = rgb_q[11:8];
    assign pix.o_g        = rgb_q[7:4];
    assign pix.o_b        = rgb_q[3:0];
    assign pix.active_sel = active_q;
    assign pix.switching  = (state_q != S_IDLE);

endmodule

// File: tb/tb_pixel_source_switch.sv
module tb_pixel_source_switch;

    localparam int D      = 8;
    localparam int BF     = 2;
    localparam int H_TOT  = 16;
    localparam int V_TOT  = 4;
    localparam int FRAME  = H_TOT * V_TOT;

    localparam int PH_SHOWING  = 0;
    localparam int PH_AWAITING = 1;
    localparam int PH_BLACK    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    pixel_source_switch_if pif();

    pixel_source_switch #(.DEBOUNCE_CYCLES(D), .BLANK_FRAMES(BF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pix   (pif)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int hpos, vpos;
    bit run_pix;

    // Reference model: select history window, switch phase, committed code.
    logic [2:0]  hist[$];
    logic [2:0]  m_stable, m_active, m_pending;
    int          m_phase;
    int          m_black_done;
    logic [11:0] m_rgb;

    typedef struct {
        logic [2:0]  sel;
        logic [11:0] exp_rgb;
    } vec_t;
    vec_t vecs[8];

    function automatic logic [11:0] dut_rgb();
        return {pif.o_r, pif.o_g, pif.o_b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] src_of(input logic [2:0] code);
        case (code)
            3'b010:  return pif.rom_rgb;
            3'b100:  return pif.strip_rgb;
            3'b110:  return pif.uart_rgb;
            3'b001:  return pif.gif_rgb;
            default: return 12'hFFF;
        endcase
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < D + 3; k++) hist.push_back(3'b000);
        m_stable     = 3'b000;
        m_active     = 3'b000;
        m_pending    = 3'b000;
        m_phase      = PH_SHOWING;
        m_black_done = 0;
        m_rgb        = 12'h000;
    endtask

    // One clock edge of spec behaviour, using the inputs present at the edge.
    task automatic model_step();
        bit fs;
        bit black;
        bit all_eq;
        fs    = (pif.h_cnt == 11'd0) && (pif.v_cnt == 11'd0);
        black = 1'b0;
        hist.push_front(pif.output_select);
        void'(hist.pop_back());

        if (m_phase == PH_SHOWING) begin
            if (m_stable != m_active) begin
                m_phase   = PH_AWAITING;
                m_pending = m_stable;
            end
        end else if (m_phase == PH_AWAITING) begin
            m_pending = m_stable;
            if (m_stable == m_active) begin
                m_phase = PH_SHOWING;
            end else if (fs) begin
`ifdef SWITCH_BLANK_EN
                m_phase      = PH_BLACK;
                m_black_done = 0;
                black        = 1'b1;
`else
                m_active = m_stable;
                m_phase  = PH_SHOWING;
`endif
            end
        end else begin
            black = 1'b1;
            if (fs) begin
                m_black_done++;
                if (m_black_done == BF) begin
                    black    = 1'b0;
                    m_active = m_pending;
                    m_phase  = PH_SHOWING;
                end
            end
        end
        m_rgb = black ? 12'h000 : src_of(m_active);

        // Debounced value: the synchronised select (two samples old) has been
        // identical for D+1 consecutive samples.
        all_eq = 1'b1;
        for (int k = 2; k <= D + 2; k++) if (hist[k] != hist[2]) all_eq = 1'b0;
        if (all_eq) m_stable = hist[2];
    endtask

    task automatic set_pix(input int h, input int v);
        hpos = h;
        vpos = v;
        pif.h_cnt = 11'(h);
        pif.v_cnt = 11'(v);
    endtask

    task automatic adv_pix();
        int h, v;
        h = hpos + 1;
        v = vpos;
        if (h == H_TOT) begin
            h = 0;
            v = (v + 1 == V_TOT) ? 0 : v + 1;
        end
        set_pix(h, v);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check("rgb", dut_rgb(), m_rgb);
        check("active_sel", pif.active_sel, m_active);
        check("switching", pif.switching, m_phase != PH_SHOWING);
        if (run_pix) adv_pix();
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (pif.switching && n < limit) begin
            tick();
            n++;
        end
        check("idle_within_bound", pif.switching, 1'b0);
    endtask

    int   rise;
    int   black_cnt;
    int   n;
    bit   sw_seen;
    bit   changed;
    int   hold;

    initial begin
        vecs[0] = '{3'b010, 12'h111};
        vecs[1] = '{3'b100, 12'h222};
        vecs[2] = '{3'b110, 12'h333};
        vecs[3] = '{3'b001, 12'h444};
        vecs[4] = '{3'b000, 12'hFFF};
        vecs[5] = '{3'b011, 12'hFFF};
        vecs[6] = '{3'b101, 12'hFFF};
        vecs[7] = '{3'b111, 12'hFFF};

        run_pix = 1'b0;
        pif.output_select = 3'b000;
        pif.rom_rgb   = 12'hABC;
        pif.strip_rgb = 12'hABC;
        pif.uart_rgb  = 12'hABC;
        pif.gif_rgb   = 12'hABC;
        set_pix(5, 2);
        model_reset();

        // Reset values with every source driving ABC.
        repeat (3) @(posedge clk);
        #1;
        check("reset_rgb", dut_rgb(), 12'h000);
        check("reset_active", pif.active_sel, 3'b000);
        check("reset_switching", pif.switching, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_reset_white", dut_rgb(), 12'hFFF);

        // Toggling faster than the debounce window never starts a switch.
        pif.rom_rgb = 12'h123;
        sw_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pif.output_select = (i % 2 == 0) ? 3'b010 : 3'b000;
            repeat (4) begin
                tick();
                if (pif.switching) sw_seen = 1'b1;
            end
        end
        check("toggle_no_switch", sw_seen, 1'b0);

        // Steady hold: 2 sync flops + D debounce clocks + stable register + FSM.
        pif.output_select = 3'b010;
        rise = 0;
        for (int i = 1; i <= 40 && rise == 0; i++) begin
            tick();
            if (pif.switching) rise = i;
        end
        check("debounce_latency", rise, D + 4);
        check("active_held_midframe", pif.active_sel, 3'b000);
        repeat (5) tick();
        check("old_source_kept", dut_rgb(), 12'hFFF);

        set_pix(0, 0);
        tick();
`ifdef SWITCH_BLANK_EN
        check("blank_entry_rgb", dut_rgb(), 12'h000);
        check("blank_entry_switching", pif.switching, 1'b1);
        run_pix = 1'b1;
        adv_pix();
        wait_idle(FRAME * (BF + 2));
        check("blank_commit_active", pif.active_sel, 3'b010);
        check("blank_commit_rgb", dut_rgb(), 12'h123);
`else
        check("commit_active", pif.active_sel, 3'b010);
        check("commit_switching", pif.switching, 1'b0);
        check("commit_rgb", dut_rgb(), 12'h123);
        set_pix(1, 0);
`endif

`ifdef SWITCH_BLANK_EN
        // 010 -> 110: exactly BF full frames of black, then the UART source.
        run_pix = 1'b1;
        pif.uart_rgb = 12'h0F0;
        pif.output_select = 3'b110;
        black_cnt = 0;
        n = 0;
        while (dut_rgb() != 12'h0F0 && n < FRAME * (BF + 4)) begin
            tick();
            if (dut_rgb() == 12'h000) black_cnt++;
            n++;
        end
        check("blank_new_source", dut_rgb(), 12'h0F0);
        check("blank_cycles", black_cnt, BF * FRAME);
        check("switching_falls_on_commit", pif.switching, 1'b0);
        check("blank_active_110", pif.active_sel, 3'b110);
`endif

        // Revert before any frame boundary leaves the output untouched.
        pif.strip_rgb = 12'h0AA;
        pif.output_select = 3'b100;
        run_pix = 1'b1;
        repeat (D + 6) tick();
        wait_idle(FRAME * (BF + 2));
        check("revert_setup_active", pif.active_sel, 3'b100);
        run_pix = 1'b0;
        set_pix(7, 1);
        changed = 1'b0;
        pif.output_select = 3'b001;
        repeat (D + 6) begin
            tick();
            if (dut_rgb() != 12'h0AA) changed = 1'b1;
        end
        check("revert_pending", pif.switching, 1'b1);
        pif.output_select = 3'b100;
        repeat (D + 6) begin
            tick();
            if (dut_rgb() != 12'h0AA) changed = 1'b1;
        end
        check("revert_idle", pif.switching, 1'b0);
        check("revert_active", pif.active_sel, 3'b100);
        check("revert_output_steady", changed, 1'b0);

        // Reset in the middle of a switch.
        pif.output_select = 3'b010;
        repeat (D + 6) tick();
`ifdef SWITCH_BLANK_EN
        set_pix(0, 0);
        tick();
        set_pix(3, 0);
        repeat (3) tick();
        check("in_blank_before_reset", dut_rgb(), 12'h000);
`endif
        check("switching_before_reset", pif.switching, 1'b1);
        pif.output_select = 3'b000;
        rst_n = 1'b0;
        #2;
        model_reset();
        check("midswitch_reset_rgb", dut_rgb(), 12'h000);
        check("midswitch_reset_active", pif.active_sel, 3'b000);
        check("midswitch_reset_switching", pif.switching, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("after_reset_idle", pif.switching, 1'b0);
        check("after_reset_active", pif.active_sel, 3'b000);

        // Table: every select code through a full switch.
        pif.rom_rgb   = 12'h111;
        pif.strip_rgb = 12'h222;
        pif.uart_rgb  = 12'h333;
        pif.gif_rgb   = 12'h444;
        run_pix = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pif.output_select = vecs[i].sel;
            repeat (D + 6) tick();
            wait_idle(FRAME * (BF + 2));
            tick();
            check("table_active", pif.active_sel, vecs[i].sel);
            check("table_rgb", dut_rgb(), vecs[i].exp_rgb);
        end

        // Random select holds, source values and free-running raster.
        hold = 0;
        for (int i = 0; i < 6000; i++) begin
            if (hold == 0) begin
                pif.output_select = 3'($urandom_range(0, 7));
                hold = $urandom_range(1, 3 * D);
            end
            hold--;
            if ($urandom_range(0, 3) == 0) begin
                pif.rom_rgb   = 12'($urandom);
                pif.strip_rgb = 12'($urandom);
                pif.uart_rgb  = 12'($urandom);
                pif.gif_rgb   = 12'($urandom);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
